glitch_filter_sync: RTL and testbench

//   Downstream consumer of the gate-level delay stage. Its combinational output carries

---
 rtl/glitch_filter_pkg.sv | 23 ++
 rtl/glitch_filter_sync_if.sv | 49 ++++
 rtl/glitch_filter_sync_chain.sv | 35 +++
 rtl/glitch_filter_sync.sv | 151 +++++++++++++++
 tb/tb_glitch_filter_sync.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/glitch_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glitch_filter_pkg
// Brief    : Shared types and helpers for the glitch filter / synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
package glitch_filter_pkg;

    // Filter state: stable low, checking a rise, stable high, checking a fall.
    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } filt_state_t;

    // Stability counter width, wide enough to hold the value 'stable'.
    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/glitch_filter_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : glitch_filter_sync_if
// Brief    : Signal bundle between the delay-stage output, the glitch filter
//            and its downstream consumer. glitch_cnt is present only when
//            GLITCH_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface glitch_filter_sync_if #(
    parameter int GCNT_W = 8
) ();

    logic              async_in;
    logic              filt_out;
    logic              rise_pulse;
    logic              fall_pulse;
`ifdef GLITCH_COUNT_EN
    logic [GCNT_W-1:0] glitch_cnt;
`endif

    // A zero-width glitch counter is meaningless.
    if (GCNT_W < 1) begin : g_bad_gcnt_w
        $error("glitch_filter_sync_if: GCNT_W must be >= 1");
    end

    // Source/consumer side: drives the raw level, observes the filter.
    modport master (
        output async_in,
        input  filt_out,
        input  rise_pulse,
        input  fall_pulse
`ifdef GLITCH_COUNT_EN
        , input glitch_cnt
`endif
    );

    // Filter side.
    modport slave (
        input  async_in,
        output filt_out,
        output rise_pulse,
        output fall_pulse
`ifdef GLITCH_COUNT_EN
        , output glitch_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/glitch_filter_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : Generic single-bit multi-flop synchroniser, reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic async_in,
    output logic      s_in
);

    // Fewer than two flops gives no metastability settling time.
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] r_sync;

    // Shift the raw level through the chain; MSB is the synchronised output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
        end
    end

    assign s_in = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/glitch_filter_sync.sv
`default_nettype none
// ============================================================================
// Module   : glitch_filter_sync
// Brief    : Synchronises an asynchronous, possibly glitchy level into clk,
//            accepts a new level only after STABLE_CYCLES stable synced
//            cycles, and emits a clean level plus rise/fall strobes.
//            Optional macro GLITCH_COUNT_EN adds a saturating counter of
//            rejected transitions (bus.glitch_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module glitch_filter_sync
    import glitch_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int GCNT_W        = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    glitch_filter_sync_if.slave  bus
);

    localparam int                 c_CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("glitch_filter_sync: STABLE_CYCLES must be >= 1");
    end
    if (GCNT_W < 1) begin : g_bad_gcnt_w
        $error("glitch_filter_sync: GCNT_W must be >= 1");
    end

    logic               w_s_in;
    filt_state_t        r_state;
    filt_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_filt_nxt;
    logic               r_filt;
    logic               r_rise;
    logic               r_fall;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.async_in),
        .s_in     (w_s_in)
    );

    // State and stability-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a reversion of s_in always wins over count completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            LOW: begin
                if (w_s_in) begin
                    w_state_nxt = CHK_HIGH;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            CHK_HIGH: begin
                if (!w_s_in) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            HIGH: begin
                if (!w_s_in) begin
                    w_state_nxt = CHK_LOW;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            CHK_LOW: begin
                if (w_s_in) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The filtered level holds its old value while a new one is being checked.
    assign w_filt_nxt = (w_state_nxt == HIGH) || (w_state_nxt == CHK_LOW);

    // Output level and strobes, all timed to the edge the level changes on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_filt <= w_filt_nxt;
            r_rise <= w_filt_nxt & ~r_filt;
            r_fall <= ~w_filt_nxt & r_filt;
        end
    end

    assign bus.filt_out   = r_filt;
    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;

`ifdef GLITCH_COUNT_EN
    logic              w_abort;
    logic [GCNT_W-1:0] r_gcnt;

    // A check aborts when s_in returns to the level of the origin state.
    assign w_abort = ((r_state == CHK_HIGH) && !w_s_in) ||
                     ((r_state == CHK_LOW)  &&  w_s_in);

    // Saturating count of rejected transitions; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcnt <= '0;
        end else if (w_abort && (r_gcnt != {GCNT_W{1'b1}})) begin
            r_gcnt <= r_gcnt + GCNT_W'(1);
        end
    end

    assign bus.glitch_cnt = r_gcnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_glitch_filter_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitch_filter_sync
// Brief    : Directed self-checking bench for glitch_filter_sync
//            (SYNC_STAGES=2, STABLE_CYCLES=4). glitch_cnt checks and the
//            GCNT_W=2 saturation instance exist when GLITCH_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_filter_sync;

    logic clk;
    logic rst_n;
    logic async_in;
    int   checks;
    int   errors;

    glitch_filter_sync_if #(.GCNT_W(8)) bus ();
    assign bus.async_in = async_in;

    glitch_filter_sync #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .GCNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef GLITCH_COUNT_EN
    glitch_filter_sync_if #(.GCNT_W(2)) bus2 ();
    assign bus2.async_in = async_in;

    glitch_filter_sync #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .GCNT_W        (2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        async_in = 1'b0;
        rst_n    = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_filt", 8'(bus.filt_out), 8'd0);
        check("rst_rise", 8'(bus.rise_pulse), 8'd0);
        check("rst_fall", 8'(bus.fall_pulse), 8'd0);
`ifdef GLITCH_COUNT_EN
        check("rst_gcnt", bus.glitch_cnt, 8'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        check("idle_filt", 8'(bus.filt_out), 8'd0);

        // Test 1: rise with 7-edge latency
        @(negedge clk) async_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t1_wait_filt", 8'(bus.filt_out), 8'd0);
            check("t1_wait_rise", 8'(bus.rise_pulse), 8'd0);
        end
        tick();
        check("t1_filt", 8'(bus.filt_out), 8'd1);
        check("t1_rise", 8'(bus.rise_pulse), 8'd1);
        check("t1_fall", 8'(bus.fall_pulse), 8'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t1_hold_filt", 8'(bus.filt_out), 8'd1);
            check("t1_hold_rise", 8'(bus.rise_pulse), 8'd0);
        end
`ifdef GLITCH_COUNT_EN
        check("t1_gcnt", bus.glitch_cnt, 8'd0);
`endif

        // Test 2: fall with 7-edge latency
        @(negedge clk) async_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t2_wait_filt", 8'(bus.filt_out), 8'd1);
            check("t2_wait_fall", 8'(bus.fall_pulse), 8'd0);
        end
        tick();
        check("t2_filt", 8'(bus.filt_out), 8'd0);
        check("t2_fall", 8'(bus.fall_pulse), 8'd1);
        check("t2_rise", 8'(bus.rise_pulse), 8'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t2_hold_filt", 8'(bus.filt_out), 8'd0);
            check("t2_hold_fall", 8'(bus.fall_pulse), 8'd0);
            check("t2_hold_rise", 8'(bus.rise_pulse), 8'd0);
        end

        // Test 3: 2-cycle high glitch from LOW is rejected and counted
        @(negedge clk) async_in = 1'b1;
        repeat (2) tick();
        @(negedge clk) async_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_filt", 8'(bus.filt_out), 8'd0);
            check("t3_rise", 8'(bus.rise_pulse), 8'd0);
            check("t3_fall", 8'(bus.fall_pulse), 8'd0);
        end
`ifdef GLITCH_COUNT_EN
        check("t3_gcnt", bus.glitch_cnt, 8'd1);
        check("t3_gcnt_w2", 8'(bus2.glitch_cnt), 8'd1);
`endif

        // Test 4: async reset in CHK_HIGH (cnt=2), then full latency again
        @(negedge clk) async_in = 1'b1;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_filt", 8'(bus.filt_out), 8'd0);
        check("t4_rst_rise", 8'(bus.rise_pulse), 8'd0);
        check("t4_rst_fall", 8'(bus.fall_pulse), 8'd0);
`ifdef GLITCH_COUNT_EN
        check("t4_rst_gcnt", bus.glitch_cnt, 8'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t4_wait_filt", 8'(bus.filt_out), 8'd0);
        end
        tick();
        check("t4_filt", 8'(bus.filt_out), 8'd1);
        check("t4_rise", 8'(bus.rise_pulse), 8'd1);
        repeat (4) tick();
        check("t4_settle_rise", 8'(bus.rise_pulse), 8'd0);

        // Test 5: five 2-cycle low glitches from HIGH
        for (int g = 0; g < 5; g++) begin
            @(negedge clk) async_in = 1'b0;
            repeat (2) tick();
            @(negedge clk) async_in = 1'b1;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("t5_filt", 8'(bus.filt_out), 8'd1);
                check("t5_fall", 8'(bus.fall_pulse), 8'd0);
            end
`ifdef GLITCH_COUNT_EN
            check("t5_gcnt", bus.glitch_cnt, 8'(g + 1));
            check("t5_gcnt_w2", 8'(bus2.glitch_cnt), (g >= 2) ? 8'd3 : 8'(g + 1));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
